// File: rtl/pc_seq_pkg.sv
// Package: pc_seq_pkg
// Shared types and constants for the fetch PC sequencer.
//   state_t          sequencer FSM state (run / halted / single-step)
//   DEFAULT_RESET_PC default fetch address after reset
//   PC_INC           sequential fetch increment in bytes
package pc_seq_pkg;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HALT = 2'd1,
    S_STEP = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam int          PC_INC           = 4;

endpackage

// File: rtl/pc_perf_counter.sv
// Module: pc_perf_counter
// Free-running, wrapping event counter used for sequencer performance stats.
// Ports:
//   clk    in   1     system clock
//   rst    in   1     asynchronous, active-high reset (clears count)
//   en     in   1     count this cycle
//   count  out  XLEN  current count, wraps mod 2^XLEN
module pc_perf_counter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  output logic [XLEN-1:0] count
);

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples values from before the edge, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + XLEN'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Module: pc_sequencer
// Owns the fetch PC and sequences it each cycle: +4, EX-stage jal/branch/jalr
// redirect, load-use stall, and debug halt / single-step. Also drives the
// pipeline enable and the IF/ID, ID/EX stall/flush controls.
// Configuration macro: PC_PERF_CNT_EN -- when defined, redirect and load-use
// stall counters are built; otherwise both counter outputs are tied to 0.
// Ports:
//   clk           in   1     system clock
//   rst           in   1     asynchronous, active-high reset
//   ex_jal        in   1     EX-stage instruction is jal
//   ex_br         in   1     EX-stage branch resolved taken
//   ex_jalr       in   1     EX-stage instruction is jalr
//   ex_pc_jal_br  in   XLEN  jal/branch target
//   ex_pc_jalr    in   XLEN  jalr target (bit0 not yet cleared)
//   ld_use        in   1     load-use dependency in ID
//   dbg_halt      in   1     debug halt request (level)
//   dbg_step      in   1     single-step pulse while halted
//   pc            out  XLEN  current fetch PC
//   pipe_en       out  1     global pipeline advance enable
//   stall_ifid    out  1     hold IF/ID
//   flush_ifid    out  1     bubble IF/ID
//   flush_idex    out  1     bubble ID/EX
//   halted        out  1     sequencer is halted
//   misalign      out  1     sticky: a redirect target had bit1 set
//   redirect_cnt  out  XLEN  taken redirect count
//   stall_cnt     out  XLEN  load-use stall cycle count
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_jal,
  input  logic            ex_br,
  input  logic            ex_jalr,
  input  logic [XLEN-1:0] ex_pc_jal_br,
  input  logic [XLEN-1:0] ex_pc_jalr,
  input  logic            ld_use,
  input  logic            dbg_halt,
  input  logic            dbg_step,
  output logic [XLEN-1:0] pc,
  output logic            pipe_en,
  output logic            stall_ifid,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic            halted,
  output logic            misalign,
  output logic [XLEN-1:0] redirect_cnt,
  output logic [XLEN-1:0] stall_cnt
);

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc_nxt;
  logic [XLEN-1:0] target;
  logic            redirect;
  logic            redirect_evt;
  logic            stall_evt;

  // ---------------------------------------------------------------------------
  // Debug FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_RUN:  if (dbg_halt) state_nxt = S_HALT;
      // Dropping the halt request wins over a simultaneous step pulse.
      S_HALT: if (!dbg_halt)     state_nxt = S_RUN;
              else if (dbg_step) state_nxt = S_STEP;
      S_STEP: state_nxt = dbg_halt ? S_HALT : S_RUN;
      default: state_nxt = S_RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-PC selection and hazard events
  // ---------------------------------------------------------------------------
  assign pipe_en = (state != S_HALT);

  always_comb begin
    target       = ex_pc_jal_br;
    redirect     = 1'b0;
    pc_nxt       = pc;
    // jal/branch takes priority over jalr, so an illegal jal+jalr pair is
    // still resolved deterministically.
    if (ex_jal || ex_br) begin
      target   = ex_pc_jal_br;
      redirect = 1'b1;
    end else if (ex_jalr) begin
      target   = ex_pc_jalr & ~XLEN'(1);
      redirect = 1'b1;
    end

    if (pipe_en) begin
      if (redirect)    pc_nxt = target;
      else if (ld_use) pc_nxt = pc;
      else             pc_nxt = pc + XLEN'(PC_INC);
    end
  end

  // A redirect overrides a load-use stall: the stalled instruction is wrong-path.
  assign redirect_evt = pipe_en && redirect;
  assign stall_evt    = pipe_en && ld_use && !redirect;

  // ---------------------------------------------------------------------------
  // PC and sticky misalign flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      misalign <= 1'b0;
    end else begin
      pc <= pc_nxt;
      if (redirect_evt && target[1]) misalign <= 1'b1;
    end
  end

  // Hazard outputs are forced quiet while reset is asserted, since the EX
  // inputs are not meaningful then.
  assign flush_ifid = redirect_evt && !rst;
  assign flush_idex = (redirect_evt || stall_evt) && !rst;
  assign stall_ifid = stall_evt && !rst;
  assign halted     = (state == S_HALT);

  // ---------------------------------------------------------------------------
  // Optional performance counters
  // ---------------------------------------------------------------------------
`ifdef PC_PERF_CNT_EN
  pc_perf_counter #(.XLEN(XLEN)) u_redirect_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (redirect_evt),
    .count (redirect_cnt)
  );

  pc_perf_counter #(.XLEN(XLEN)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (stall_evt),
    .count (stall_cnt)
  );
`else
  assign redirect_cnt = '0;
  assign stall_cnt    = '0;
`endif

endmodule
